// File: rtl/demux_1_to_6_reg_pkg.sv
// Shared definitions for the registered 1-to-6 one-hot demultiplexer:
// lane select encodings and select decode helpers.
package demux_1_to_6_reg_pkg;

  localparam int N_LANES = 6;

  localparam logic [N_LANES-1:0] SEL_L0 = 6'b000001;
  localparam logic [N_LANES-1:0] SEL_L1 = 6'b000010;
  localparam logic [N_LANES-1:0] SEL_L2 = 6'b000100;
  localparam logic [N_LANES-1:0] SEL_L3 = 6'b001000;
  localparam logic [N_LANES-1:0] SEL_L4 = 6'b010000;
  localparam logic [N_LANES-1:0] SEL_L5 = 6'b100000;

  function automatic logic [2:0] onehot_to_idx(input logic [N_LANES-1:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    case (sel)
      SEL_L0:  idx = 3'd0;
      SEL_L1:  idx = 3'd1;
      SEL_L2:  idx = 3'd2;
      SEL_L3:  idx = 3'd3;
      SEL_L4:  idx = 3'd4;
      SEL_L5:  idx = 3'd5;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [N_LANES-1:0] sel);
    int ones;
    ones = 0;
    for (int i = 0; i < N_LANES; i++) begin
      if (sel[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/demux_1_to_6_reg_lane.sv
// One demultiplexer lane: a data holding register with a valid flag that is
// set by a write and cleared by the consumer's ack; a write wins over an ack.
module demux_1_to_6_reg_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en_i) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end else if (ack_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_1_to_6_reg.sv
// Registered 1-to-6 one-hot demultiplexer between the ALU result path and the
// six consumers; tracks last select, accepted-write count and bad-select errors.
module demux_1_to_6_reg
  import demux_1_to_6_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = N_LANES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [N-1:0]       in_sel,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ack,
  output logic [N-1:0]       last_sel,
  output logic [7:0]         wr_count,
  output logic               err_sel,
  input  logic               err_clr
);

  logic         selLegal;
  logic [2:0]   selIdx;
  logic         accept;
  logic [N-1:0] wrEn;

  logic [N-1:0] lastSel_q, lastSel_d;
  logic [7:0]   wrCount_q, wrCount_d;
  logic         errSel_q, errSel_d;

  // Illegal selects are always taken (and dropped) so a bad producer never stalls.
  always_comb begin
    selLegal = is_onehot(in_sel);
    selIdx   = onehot_to_idx(in_sel);
    in_ready = !selLegal || !out_valid[selIdx] || out_ack[selIdx];
    accept   = in_valid && in_ready && selLegal;
    wrEn     = accept ? in_sel : '0;
  end

  always_comb begin
    lastSel_d = lastSel_q;
    wrCount_d = wrCount_q;
    errSel_d  = errSel_q;
    if (accept) begin
      lastSel_d = in_sel;
      wrCount_d = wrCount_q + 8'd1;
    end
    if (in_valid && !selLegal) begin
      errSel_d = 1'b1;
    end else if (err_clr) begin
      errSel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lastSel_q <= '0;
      wrCount_q <= '0;
      errSel_q  <= 1'b0;
    end else begin
      lastSel_q <= lastSel_d;
      wrCount_q <= wrCount_d;
      errSel_q  <= errSel_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : gLane
    demux_1_to_6_reg_lane #(
      .WIDTH(WIDTH)
    ) uLane (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .wr_en_i  (wrEn[i]),
      .wr_data_i(in_data),
      .ack_i    (out_ack[i]),
      .data_o   (out_data[i*WIDTH +: WIDTH]),
      .valid_o  (out_valid[i])
    );
  end

  assign last_sel = lastSel_q;
  assign wr_count = wrCount_q;
  assign err_sel  = errSel_q;

endmodule
